// File: rtl/serv_dbus_pkg.sv
// Shared types and helpers for the serial data-bus stage: state encoding,
// access-size codes and the byte-lane / alignment rules.
package serv_dbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_BUS       = 3'd2,
        ST_SHIFT_OUT = 3'd3,
        ST_DONE_ERR  = 3'd4
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Byte-lane enables; size 2'b11 behaves as a word.
    function automatic logic [3:0] dbus_sel(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] sel;
        case (size)
            SZ_B:    sel = 4'b0001 << lsb;
            SZ_H:    sel = lsb[1] ? 4'b1100 : 4'b0011;
            SZ_W:    sel = 4'b1111;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic dbus_misalign(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lsb[0];
            SZ_W:    mis = (lsb != 2'b00);
            default: mis = (lsb != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/serv_dbus_bus_if.sv
// Classic-cycle Wishbone data-bus bundle between the serial core and memory.
interface serv_dbus_bus_if;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdt;
    logic        ack;

    modport master (output cyc, output we, output sel, output dat, input rdt, input ack);
    modport slave  (input cyc, input we, input sel, input dat, output rdt, output ack);
endinterface

// File: rtl/serv_dbus_ext.sv
// Picks one bit of a loaded word for the serial return path, selecting the
// byte/halfword lane and replicating the sign (or zero) above it.
module serv_dbus_ext
    import serv_dbus_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lsb,
    input  logic        i_signed,
    input  logic [4:0]  i_idx,
    output logic        o_rd
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sign_s;

    // Lane select and extension for bit index i_idx.
    always_comb begin
        byte_s = 8'(i_data >> {i_lsb, 3'b000});
        half_s = 16'(i_data >> {i_lsb[1], 4'b0000});
        sign_s = 1'b0;
        o_rd   = 1'b0;
        case (i_size)
            SZ_B: begin
                sign_s = i_signed & byte_s[7];
                o_rd   = (i_idx < 5'd8) ? byte_s[i_idx[2:0]] : sign_s;
            end
            SZ_H: begin
                sign_s = i_signed & half_s[15];
                o_rd   = (i_idx < 5'd16) ? half_s[i_idx[3:0]] : sign_s;
            end
            SZ_W:    o_rd = i_data[i_idx];
            default: o_rd = i_data[i_idx];
        endcase
    end
endmodule

// File: rtl/serv_dbus_if.sv
// Data-bus stage: serially gathers store data, runs one classic Wishbone
// cycle, and serially returns aligned, extended load data.
module serv_dbus_if
    import serv_dbus_pkg::*;
#(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_we,
    input  logic [1:0]      i_size,
    input  logic            i_signed,
    input  logic [1:0]      i_lsb,
    input  logic            i_en,
    input  logic            i_rs2,
    output logic            o_rd,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_misalign,
    serv_dbus_bus_if.master dbus
);
    state_e      state_r, state_s;
    logic [4:0]  cnt_r;
    logic [31:0] data_r;
    logic        we_r, signed_r;
    logic [1:0]  size_r, lsb_r;
    logic        cyc_r, bus_we_r, busy_r, done_r, misalign_r;
    logic [3:0]  sel_r;
    logic        mis_s, trap_s, ack_s, shift_s, last_s, cyc_next_s, ext_rd_s;

    // Request decode and handshake qualifiers; acks count only once cyc is visible.
    always_comb begin
        mis_s      = dbus_misalign(i_size, i_lsb);
        trap_s     = mis_s & MISALIGN_TRAP;
        ack_s      = (state_r == ST_BUS) & cyc_r & dbus.ack;
        shift_s    = ((state_r == ST_SHIFT_IN) | (state_r == ST_SHIFT_OUT)) & i_en;
        last_s     = shift_s & (cnt_r == 5'd31);
        cyc_next_s = (state_r == ST_BUS) & ~ack_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    if (trap_s)    state_s = ST_DONE_ERR;
                    else if (i_we) state_s = ST_SHIFT_IN;
                    else           state_s = ST_BUS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DONE_ERR: state_s = ST_IDLE;
            ST_SHIFT_IN: begin
                if (last_s) state_s = ST_BUS;
                else        state_s = ST_SHIFT_IN;
            end
            ST_BUS: begin
                if (ack_s) state_s = we_r ? ST_IDLE : ST_SHIFT_OUT;
                else       state_s = ST_BUS;
            end
            ST_SHIFT_OUT: begin
                if (last_s) state_s = ST_IDLE;
                else        state_s = ST_SHIFT_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Bit counter; wraps to zero on the 32nd step so every phase starts at 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)     cnt_r <= 5'd0;
        else if (shift_s) cnt_r <= cnt_r + 5'd1;
        else              cnt_r <= cnt_r;
    end

    // Request fields; a non-trapping misaligned access runs as if aligned.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            we_r     <= 1'b0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            lsb_r    <= 2'b00;
        end else if ((state_r == ST_IDLE) && i_start) begin
            we_r     <= i_we;
            size_r   <= i_size;
            signed_r <= i_signed;
            lsb_r    <= mis_s ? 2'b00 : i_lsb;
        end else begin
            we_r     <= we_r;
            size_r   <= size_r;
            signed_r <= signed_r;
            lsb_r    <= lsb_r;
        end
    end

    // Shared data register: store bits enter at the top, load data lands on ack.
    always_ff @(posedge i_clk) begin
        if ((state_r == ST_SHIFT_IN) && i_en) data_r <= {i_rs2, data_r[31:1]};
        else if (ack_s && !we_r)              data_r <= dbus.rdt;
        else                                  data_r <= data_r;
    end

    // Registered bus and status outputs; cyc drops on the ack edge itself.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cyc_r      <= 1'b0;
            bus_we_r   <= 1'b0;
            sel_r      <= 4'b0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            cyc_r      <= cyc_next_s;
            bus_we_r   <= cyc_next_s & we_r;
            sel_r      <= cyc_next_s ? dbus_sel(size_r, lsb_r) : 4'b0000;
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= ack_s | (state_r == ST_DONE_ERR);
            misalign_r <= (state_r == ST_DONE_ERR);
        end
    end

    serv_dbus_ext u_ext (
        .i_data   (data_r),
        .i_size   (size_r),
        .i_lsb    (lsb_r),
        .i_signed (signed_r),
        .i_idx    (cnt_r),
        .o_rd     (ext_rd_s)
    );

    assign o_rd       = (state_r == ST_SHIFT_OUT) ? ext_rd_s : 1'b0;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_misalign = misalign_r;
    assign dbus.cyc   = cyc_r;
    assign dbus.we    = bus_we_r;
    assign dbus.sel   = sel_r;
    assign dbus.dat   = data_r << {lsb_r, 3'b000};

endmodule
